// File: rtl/lc3b_types.sv
// Shared LC-3b core types: register numbers, hazard FSM states and the pipeline NOP word.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic {
        PH1,
        PH2
    } hazard_state_t;

    // BR with no condition bits set never branches, so all-zero is the NOP.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, holds at all-ones, cleared by rst.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control.sv
// Stall/bubble/flush controller for the five-stage LC-3b pipe.
// Statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_control
    import lc3b_types::*;
#(
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_read,
    input  logic              imem_resp,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_indirect,
    input  logic              dmem_resp,
    input  logic              mem_br_taken,
    input  logic              ex_load_regfile,
    input  logic              ex_mem_read,
    input  lc3b_reg           ex_dest,
    input  lc3b_reg           id_sr1,
    input  lc3b_reg           id_sr2,
    input  logic              id_uses_sr1,
    input  logic              id_uses_sr2,
    output logic              dmem_phase,
    output logic              load_pc,
    output logic              load_if_id,
    output logic              load_id_ex,
    output logic              load_ex_mem,
    output logic              load_mem_wb,
    output logic              id_ex_bubble,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] bubble_count,
    output logic [STAT_W-1:0] flush_count
);

    hazard_state_t state_q, state_d;

    logic mem_access;
    logic mem_done;
    logic if_done;
    logic stall;
    logic load_use;
    logic br_flush;

    assign mem_access = mem_read | mem_write;
    assign mem_done   = !mem_access | (dmem_resp & ((state_q == PH2) | !mem_indirect));
    assign if_done    = !imem_read | imem_resp;
    assign stall      = !rst & (!mem_done | !if_done);
    assign load_use   = ex_mem_read & ex_load_regfile &
                        ((id_uses_sr1 & (id_sr1 == ex_dest)) |
                         (id_uses_sr2 & (id_sr2 == ex_dest)));
    assign br_flush   = !rst & !stall & mem_br_taken;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PH1: if (mem_access && mem_indirect && dmem_resp) state_d = PH2;
            PH2: if (dmem_resp) state_d = PH1;
            default: state_d = PH1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PH1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        dmem_phase   = (state_q == PH2) & !rst;
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (rst || br_flush) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (stall) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (load_use) begin
            // One bubble suffices: next cycle the load sits in MEM and forwarding covers it.
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    sat_counter #(.W(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (stall_cycles)
    );

    sat_counter #(.W(STAT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (id_ex_bubble),
        .count (bubble_count)
    );

    sat_counter #(.W(STAT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_flush),
        .count (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign bubble_count = '0;
    assign flush_count  = '0;
`endif

endmodule
